cordic_iter_multi: RTL and testbench

//  Parametrised iterative CORDIC for the FOC datapath: one micro-rotation per clock,

---
 rtl/cordic_iter_multi.sv | 260 ++++++++++++++++++++++++++
 tb/tb_cordic_iter_multi.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_multi.sv
// Iterative CORDIC, one micro-rotation per clock, rotation (sin/cos) and vectoring (mag/angle) modes.
// Latency start -> done_o: ITER+1 cycles, or ITER+2 with gain compensation.
// No backpressure: start_i is only sampled in IDLE, and results are held until the next done_o.
module cordic_iter_multi #(
    parameter int W         = 18,
    parameter int ITER      = 16,
    parameter int GAIN_COMP = 0
) (
    input  logic         sys_clk_i,
    input  logic         reset_n_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [W-1:0] theta_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic [W-1:0] theta_o
);

    // x/y carry two guard bits so the CORDIC gain (~1.647) cannot overflow.
    localparam int DW = W + 2;
    localparam int CW = $clog2(ITER);
    // The product width covers a DW-bit operand times the 17-bit positive gain constant.
    localparam int PW = DW + 17;

    localparam logic [CW-1:0]        LAST_ITER   = CW'(ITER - 1);
    localparam logic signed [W-1:0]  PI_HALF     = {2'b01, {(W-2){1'b0}}};
    localparam logic signed [W-1:0]  NEG_PI_HALF = {2'b11, {(W-2){1'b0}}};
    // +pi and -pi share one code once wrapped to W bits.
    localparam logic signed [W-1:0]  PI_WRAP     = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [DW-1:0] SAT_MAX     = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [DW-1:0] SAT_MIN     = {3'b111, {(W-1){1'b0}}};
    localparam logic signed [PW-1:0] K_GAIN      = PW'(39797);   // 0x9B75 = 0.607253 in Q16
    localparam logic signed [PW-1:0] HALF_LSB    = PW'(32768);   // round half-up before >>> 16

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_SCALE,
        S_DONE
    } state_t;

    // atan(2^-i) with 2^31 = pi.
    function automatic logic [31:0] atan_q31(input int i);
        case (i)
            0:       return 32'h20000000;
            1:       return 32'h12E4051E;
            2:       return 32'h09FB385B;
            3:       return 32'h051111D4;
            4:       return 32'h028B0D43;
            5:       return 32'h0145D7E1;
            6:       return 32'h00A2F61E;
            7:       return 32'h00517C55;
            8:       return 32'h0028BE53;
            9:       return 32'h00145F2F;
            10:      return 32'h000A2F98;
            11:      return 32'h000517CC;
            12:      return 32'h00028BE6;
            13:      return 32'h000145F3;
            14:      return 32'h0000A2FA;
            15:      return 32'h0000517D;
            16:      return 32'h000028BE;
            17:      return 32'h0000145F;
            18:      return 32'h00000A30;
            19:      return 32'h00000518;
            20:      return 32'h0000028C;
            21:      return 32'h00000146;
            22:      return 32'h000000A3;
            23:      return 32'h00000051;
            default: return 32'h00000000;
        endcase
    endfunction

    // Rescale a table entry to W-bit angle units, rounding to nearest.
    function automatic logic [W-1:0] atan_w(input int i);
        logic [32:0] sum;
        logic [32:0] shifted;
        sum     = {1'b0, atan_q31(i)} + (33'd1 << (31 - W));
        shifted = sum >> (32 - W);
        return shifted[W-1:0];
    endfunction

    // Clamp an internal value to the signed W-bit output range.
    function automatic logic [W-1:0] sat_w(input logic signed [DW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return v[W-1:0];
    endfunction

    logic [W-1:0] atan_lut [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_atan_lut
        assign atan_lut[g] = atan_w(g);
    end

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         cnt_q;
    logic                  mode_q;
    logic signed [DW-1:0]  x_q;
    logic signed [DW-1:0]  y_q;
    logic signed [W-1:0]   z_q;

    logic signed [DW-1:0]  x_pre;
    logic signed [DW-1:0]  y_pre;
    logic signed [W-1:0]   z_pre;
    logic signed [DW-1:0]  x_ext;
    logic signed [DW-1:0]  y_ext;
    logic signed [W-1:0]   theta_s;

    logic signed [DW-1:0]  x_sh;
    logic signed [DW-1:0]  y_sh;
    logic signed [W-1:0]   atan_cur;
    logic                  d_pos;
    logic signed [DW-1:0]  x_nxt;
    logic signed [DW-1:0]  y_nxt;
    logic signed [W-1:0]   z_nxt;

    logic signed [PW-1:0]  prod_x;
    logic signed [PW-1:0]  prod_y;
    logic signed [DW-1:0]  x_sc;
    logic signed [DW-1:0]  y_sc;

    // Quadrant pre-rotation folds the operand into the +/-pi/2 convergence range.
    always_comb begin
        x_ext   = {{2{x_i[W-1]}}, x_i};
        y_ext   = {{2{y_i[W-1]}}, y_i};
        theta_s = $signed(theta_i);
        x_pre   = x_ext;
        y_pre   = y_ext;
        z_pre   = theta_s;
        if (mode_i) begin
            z_pre = '0;
            if (x_i[W-1]) begin
                x_pre = -x_ext;
                y_pre = -y_ext;
                z_pre = PI_WRAP;
            end
        end else if ((theta_s > PI_HALF) || (theta_s < NEG_PI_HALF)) begin
            // Adding or subtracting pi modulo 2pi is just an MSB flip.
            x_pre = -x_ext;
            y_pre = -y_ext;
            z_pre = {~theta_i[W-1], theta_i[W-2:0]};
        end
    end

    // One micro-rotation; direction chosen from z (rotation) or y (vectoring), zero counts as +1.
    always_comb begin
        x_sh     = x_q >>> cnt_q;
        y_sh     = y_q >>> cnt_q;
        atan_cur = $signed(atan_lut[cnt_q]);
        d_pos    = mode_q ? (y_q[DW-1] || (y_q == '0)) : !z_q[W-1];
        if (d_pos) begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_cur;
        end else begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + atan_cur;
        end
    end

    // Gain compensation: multiply by K in Q16, round half-up.
    always_comb begin
        prod_x = PW'(x_q) * K_GAIN;
        prod_y = PW'(y_q) * K_GAIN;
        x_sc   = DW'((prod_x + HALF_LSB) >>> 16);
        y_sc   = DW'((prod_y + HALF_LSB) >>> 16);
    end

    // State register.
    always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and busy flag.
    always_comb begin
        state_d = state_q;
        busy_o  = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = (GAIN_COMP != 0) ? S_SCALE : S_DONE;
                end
            end
            S_SCALE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture, micro-rotation and scaling registers.
    always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        x_q    <= x_pre;
                        y_q    <= y_pre;
                        z_q    <= z_pre;
                        mode_q <= mode_i;
                        cnt_q  <= '0;
                    end
                end
                S_ITER: begin
                    x_q   <= x_nxt;
                    y_q   <= y_nxt;
                    z_q   <= z_nxt;
                    cnt_q <= (cnt_q == LAST_ITER) ? '0 : cnt_q + 1'b1;
                end
                S_SCALE: begin
                    x_q <= x_sc;
                    y_q <= y_sc;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers: updated only on completion so they hold between operations.
    always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            done_o  <= 1'b0;
            x_o     <= '0;
            y_o     <= '0;
            theta_o <= '0;
        end else begin
            done_o <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                x_o     <= sat_w(x_q);
                y_o     <= sat_w(y_q);
                theta_o <= z_q;
            end
        end
    end

endmodule

// File: tb/tb_cordic_iter_multi.sv
// Directed bench for cordic_iter_multi: two instances, without and with gain compensation.
// Expected values are hand-computed from 1024*1.64676 = 1686 and its sin/cos projections.
// Arithmetic (floor) shifts bias x/y by a few LSB, hence XY_TOL.
module tb_cordic_iter_multi;

    localparam int W       = 18;
    localparam int ITER    = 16;
    localparam int XY_TOL  = 8;
    localparam int TH_TOL  = 3;
    // Vectoring angle is limited by the residual y (a couple of LSB against |x|~1.7k-2.4k).
    localparam int ANG_TOL = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] th_in = '0;

    logic         busy_a, done_a, busy_g, done_g;
    logic [W-1:0] xa, ya, tha, xg, yg, thg;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    cordic_iter_multi #(.W(W), .ITER(ITER), .GAIN_COMP(0)) u_dut_a (
        .sys_clk_i(clk), .reset_n_i(rst_n), .start_i(start), .mode_i(mode),
        .x_i(x_in), .y_i(y_in), .theta_i(th_in),
        .busy_o(busy_a), .done_o(done_a), .x_o(xa), .y_o(ya), .theta_o(tha)
    );

    cordic_iter_multi #(.W(W), .ITER(ITER), .GAIN_COMP(1)) u_dut_g (
        .sys_clk_i(clk), .reset_n_i(rst_n), .start_i(start), .mode_i(mode),
        .x_i(x_in), .y_i(y_in), .theta_i(th_in),
        .busy_o(busy_g), .done_o(done_g), .x_o(xg), .y_o(yg), .theta_o(thg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sv(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            if (!busy_a && !busy_g) break;
            @(negedge clk);
        end
    endtask

    // Single-cycle start pulse; returns the edge count just after the capturing edge.
    task automatic launch(input logic m, input int xv, input int yv, input int tv, output int c0);
        mode  = m;
        x_in  = W'(xv);
        y_in  = W'(yv);
        th_in = W'(tv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(input bit sel_g, input int budget, output int cd, output bit to);
        to = 1'b1;
        cd = 0;
        for (int k = 0; k < budget; k++) begin
            if (sel_g ? done_g : done_a) begin
                cd = cyc;
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, xa, ya, tha} !== '0) begin
            errors++;
            $display("FAIL reset_a: busy=%b done=%b x=%0d y=%0d th=%0d, want all 0", busy_a, done_a, sv(xa), sv(ya), sv(tha));
        end
        checks++;
        if ({busy_g, done_g, xg, yg, thg} !== '0) begin
            errors++;
            $display("FAIL reset_g: busy=%b done=%b x=%0d y=%0d th=%0d, want all 0", busy_g, done_g, sv(xg), sv(yg), sv(thg));
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_a, done_a, busy_g, done_g} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: busy/done a,g = %b%b%b%b, want 0000", busy_a, done_a, busy_g, done_g);
        end
    endtask

    task automatic test_rotation_quarter();
        int c0, cd, cdg;
        bit to;
        logic [W-1:0] held_y;
        wait_idle();
        launch(1'b0, 1024, 0, 'h10000, c0);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b want 1", busy_a);
        end
        wait_done(1'b0, 40, cd, to);
        checks++;
        if (to || (cd - c0) != ITER + 1) begin
            errors++;
            $display("FAIL latency_a: got %0d (timeout=%0d) want %0d", cd - c0, to, ITER + 1);
        end
        checks++;
        if (iabs(sv(xa)) > XY_TOL || iabs(sv(ya) - 1686) > XY_TOL) begin
            errors++;
            $display("FAIL rot_q_xy: got x=%0d y=%0d want 0,1686", sv(xa), sv(ya));
        end
        checks++;
        if (iabs(sv(tha)) > TH_TOL) begin
            errors++;
            $display("FAIL rot_q_theta: got %0d want 0", sv(tha));
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop_with_done: got %b want 0", busy_a);
        end
        held_y = ya;
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: got %b want 0", done_a);
        end
        wait_done(1'b1, 10, cdg, to);
        repeat (3) @(negedge clk);
        checks++;
        if (ya !== held_y) begin
            errors++;
            $display("FAIL outputs_held: got y=%0d want %0d", sv(ya), sv(held_y));
        end
        checks++;
        if (to || (cdg - c0) != ITER + 2) begin
            errors++;
            $display("FAIL latency_g: got %0d (timeout=%0d) want %0d", cdg - c0, to, ITER + 2);
        end
        checks++;
        if (iabs(sv(yg) - 1024) > XY_TOL || iabs(sv(xg)) > XY_TOL) begin
            errors++;
            $display("FAIL gain_q_xy: got x=%0d y=%0d want 0,1024", sv(xg), sv(yg));
        end
    endtask

    task automatic test_vectoring();
        int vx[3]  = '{0, -1024, -1024};
        int vy[3]  = '{1024, 1024, -1024};
        int ex[3]  = '{1686, 2385, 2385};
        int eth[3] = '{65536, 98304, -98304};
        int c0, cd;
        bit to;
        for (int k = 0; k < 3; k++) begin
            wait_idle();
            launch(1'b1, vx[k], vy[k], 0, c0);
            wait_done(1'b0, 40, cd, to);
            checks++;
            if (to || iabs(sv(xa) - ex[k]) > XY_TOL || iabs(sv(ya)) > XY_TOL) begin
                errors++;
                $display("FAIL vec%0d_xy: got x=%0d y=%0d (timeout=%0d) want %0d,0", k, sv(xa), sv(ya), to, ex[k]);
            end
            checks++;
            if (iabs(sv(tha) - eth[k]) > ANG_TOL) begin
                errors++;
                $display("FAIL vec%0d_theta: got %0d want %0d", k, sv(tha), eth[k]);
            end
        end
    endtask

    task automatic test_prerotation();
        int th[2] = '{-131072, 98304};
        int ex[2] = '{-1686, -1192};
        int ey[2] = '{0, 1192};
        int c0, cd;
        bit to;
        for (int k = 0; k < 2; k++) begin
            wait_idle();
            launch(1'b0, 1024, 0, th[k], c0);
            wait_done(1'b0, 40, cd, to);
            checks++;
            if (to || iabs(sv(xa) - ex[k]) > XY_TOL || iabs(sv(ya) - ey[k]) > XY_TOL) begin
                errors++;
                $display("FAIL prerot%0d_xy: got x=%0d y=%0d (timeout=%0d) want %0d,%0d", k, sv(xa), sv(ya), to, ex[k], ey[k]);
            end
            checks++;
            if (iabs(sv(tha)) > TH_TOL) begin
                errors++;
                $display("FAIL prerot%0d_theta: got %0d want 0", k, sv(tha));
            end
        end
    endtask

    task automatic test_back_to_back();
        int ang[14] = '{0, 21845, -21845, 32768, -32768, 43691, -43691,
                        65536, -65536, 87381, -87381, 109227, -109227, -131072};
        int ex[14]  = '{1686, 1460, 1460, 1192, 1192, 843, 843,
                        0, 0, -843, -843, -1460, -1460, -1686};
        int ey[14]  = '{0, 843, -843, 1192, -1192, 1460, -1460,
                        1686, -1686, 1460, -1460, 843, -843, 0};
        int cd, prev;
        bit to;
        wait_idle();
        prev  = 0;
        mode  = 1'b0;
        x_in  = W'(1024);
        y_in  = '0;
        th_in = W'(ang[0]);
        start = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            // Scramble inputs while busy; start stays high and must be ignored.
            mode  = 1'b1;
            x_in  = 18'h15555;
            y_in  = 18'h0ABCD;
            th_in = th_in ^ 18'h2AAAA;
            wait_done(1'b0, 40, cd, to);
            if (k > 0) begin
                checks++;
                if (to || (cd - prev) != ITER + 2) begin
                    errors++;
                    $display("FAIL sweep_spacing%0d: got %0d (timeout=%0d) want %0d", k, cd - prev, to, ITER + 2);
                end
            end
            prev = cd;
            checks++;
            if (to || iabs(sv(xa) - ex[k]) > XY_TOL || iabs(sv(ya) - ey[k]) > XY_TOL) begin
                errors++;
                $display("FAIL sweep%0d_xy: got x=%0d y=%0d want %0d,%0d", k, sv(xa), sv(ya), ex[k], ey[k]);
            end
            if (k < 13) begin
                mode  = 1'b0;
                x_in  = W'(1024);
                y_in  = '0;
                th_in = W'(ang[k + 1]);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_gain_comp();
        int c0, cd, cdg;
        bit to;
        wait_idle();
        launch(1'b0, 1024, 0, 0, c0);
        wait_done(1'b1, 40, cdg, to);
        checks++;
        if (to || (cdg - c0) != ITER + 2) begin
            errors++;
            $display("FAIL gc_latency: got %0d (timeout=%0d) want %0d", cdg - c0, to, ITER + 2);
        end
        checks++;
        if (iabs(sv(xg) - 1024) > TH_TOL || iabs(sv(yg)) > TH_TOL) begin
            errors++;
            $display("FAIL gc_xy: got x=%0d y=%0d want 1024,0", sv(xg), sv(yg));
        end
        wait_idle();
        launch(1'b0, 131071, 131071, 0, c0);
        wait_done(1'b0, 40, cd, to);
        checks++;
        if (to || sv(xa) != 131071 || sv(ya) != 131071) begin
            errors++;
            $display("FAIL sat_pos: got x=%0d y=%0d (timeout=%0d) want 131071,131071", sv(xa), sv(ya), to);
        end
        wait_done(1'b1, 10, cdg, to);
        checks++;
        if (to || iabs(sv(xg) - 131071) > XY_TOL || iabs(sv(yg) - 131071) > XY_TOL) begin
            errors++;
            $display("FAIL gc_large: got x=%0d y=%0d (timeout=%0d) want ~131071,~131071", sv(xg), sv(yg), to);
        end
        wait_idle();
        launch(1'b0, -131072, -131072, 0, c0);
        wait_done(1'b0, 40, cd, to);
        checks++;
        if (to || sv(xa) != -131072 || sv(ya) != -131072) begin
            errors++;
            $display("FAIL sat_neg: got x=%0d y=%0d (timeout=%0d) want -131072,-131072", sv(xa), sv(ya), to);
        end
    endtask

    task automatic test_reset_mid();
        int c0, cd;
        bit to, seen;
        wait_idle();
        launch(1'b0, 1024, 0, 'h10000, c0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_a, done_a, xa, ya, tha, busy_g, done_g, xg, yg, thg} !== '0) begin
            errors++;
            $display("FAIL reset_mid: a=%b%b %0d %0d %0d g=%b%b %0d %0d %0d, want all 0",
                     busy_a, done_a, sv(xa), sv(ya), sv(tha), busy_g, done_g, sv(xg), sv(yg), sv(thg));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < ITER + 6; k++) begin
            @(negedge clk);
            if (done_a || done_g || busy_a || busy_g) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL no_done_after_abort: activity seen=%b want 0", seen);
        end
        launch(1'b0, 1024, 0, 'h10000, c0);
        wait_done(1'b0, 40, cd, to);
        checks++;
        if (to || (cd - c0) != ITER + 1 || iabs(sv(ya) - 1686) > XY_TOL) begin
            errors++;
            $display("FAIL restart: got lat=%0d y=%0d (timeout=%0d) want %0d,1686", cd - c0, sv(ya), to, ITER + 1);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rotation_quarter();
        test_vectoring();
        test_prerotation();
        test_back_to_back();
        test_gain_comp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
